// File: rtl/add_sched_if.sv
// rtl/add_sched_if.sv - client-side request/result bundle for the shared-adder scheduler
interface add_sched_if #(
    parameter int SIZE = 32
);
    logic              req0;
    logic              req1;
    logic [2*SIZE-1:0] a0;
    logic [2*SIZE-1:0] b0;
    logic [2*SIZE-1:0] a1;
    logic [2*SIZE-1:0] b1;
    logic              sub0;
    logic              sub1;
    logic              done0;
    logic              done1;
    logic [2*SIZE-1:0] sum;
    logic              cout;
    logic              ovf;
    logic              owner;
    logic              busy;

    modport master (
        output req0, req1, a0, b0, a1, b1, sub0, sub1,
        input  done0, done1, sum, cout, ovf, owner, busy
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, sub0, sub1,
        output done0, done1, sum, cout, ovf, owner, busy
    );
endinterface

// File: rtl/add_sched.sv
// rtl/add_sched.sv - round-robin scheduler sequencing one 32-bit ripple adder into a 64-bit add/sub
module yAdder #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] z,
    output logic            cout
);
    logic [SIZE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SIZE; i++) begin : g_bit
        assign z[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SIZE];
endmodule

module add_sched #(
    parameter int SIZE = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    add_sched_if.slave  bus
);
    localparam int W = 2 * SIZE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            owner_q, owner_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            cin_q, cin_d;
    logic [SIZE-1:0] lo_q, lo_d;
    logic            c_mid_q, c_mid_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [SIZE-1:0] add_a, add_b, add_z;
    logic            add_cin, add_cout;
    logic            grant;

    // One adder serves both halves; the FSM state selects which word it sees.
    always_comb begin
        add_a   = a_q[SIZE-1:0];
        add_b   = b_q[SIZE-1:0];
        add_cin = cin_q;
        if (state_q == S_HIGH) begin
            add_a   = a_q[W-1:SIZE];
            add_b   = b_q[W-1:SIZE];
            add_cin = c_mid_q;
        end
    end

    yAdder #(.SIZE(SIZE)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .z    (add_z),
        .cout (add_cout)
    );

    // On a tie the client that was not served last wins.
    always_comb begin
        grant = bus.req1;
        if (bus.req0 && bus.req1) begin
            grant = ~ptr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        lo_d    = lo_q;
        c_mid_d = c_mid_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d = grant;
                    if (grant) begin
                        a_d   = bus.a1;
                        b_d   = bus.sub1 ? ~bus.b1 : bus.b1;
                        cin_d = bus.sub1;
                    end else begin
                        a_d   = bus.a0;
                        b_d   = bus.sub0 ? ~bus.b0 : bus.b0;
                        cin_d = bus.sub0;
                    end
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                lo_d    = add_z;
                c_mid_d = add_cout;
                state_d = S_HIGH;
            end
            S_HIGH: begin
                sum_d   = {add_z, lo_q};
                cout_d  = add_cout;
                ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_z[SIZE-1] != a_q[W-1]);
                state_d = S_DONE;
            end
            S_DONE: begin
                ptr_d   = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b1;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            lo_q    <= '0;
            c_mid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            lo_q    <= lo_d;
            c_mid_q <= c_mid_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.done0 = (state_q == S_DONE) && !owner_q;
    assign bus.done1 = (state_q == S_DONE) &&  owner_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
    assign bus.owner = owner_q;
endmodule
